// File: rtl/pipelined_gate_array.sv
// Bitwise gate array (AND/OR/XOR/NAND/NOR/XNOR/NOT/BUF) feeding a DEPTH-stage valid/ready pipeline.
// Optional PGA_XFER_COUNT_EN adds a saturating 16-bit count of output transfers.
module pipelined_gate_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
`ifdef PGA_XFER_COUNT_EN
    ,
    output logic [15:0]      xfer_count
`endif
);

    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;

    always_comb begin
        result = '0;
        case (op)
            3'b000: result = a & b;
            3'b001: result = a | b;
            3'b010: result = a ^ b;
            3'b011: result = ~(a & b);
            3'b100: result = ~(a | b);
            3'b101: result = ~(a ^ b);
            3'b110: result = ~a;
            3'b111: result = a;
        endcase
    end

    // A stage may advance if any stage at or after it is empty, or the output is draining.
    always_comb begin
        logic hole;
        adv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hole = 1'b0;
            for (int j = i; j < DEPTH; j++) begin
                hole = hole | ~v[j];
            end
            adv[i] = hole | out_ready;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[DEPTH-1];
    assign y         = data[DEPTH-1];

    // Data registers only load behind a valid upstream bit, so idle inputs never enter a stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else begin
            if (adv[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    data[0] <= result;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        data[i] <= data[i-1];
                    end
                end
            end
        end
    end

`ifdef PGA_XFER_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready && (xfer_count != 16'hFFFF)) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule
